// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer for an asynchronous-read
// instruction memory. Holds the PC, presents it as the memory address,
// captures each fetched word together with its PC into a one-entry output
// stage, and hands that stage to decode over a valid/ready handshake.
// Supports start, decode backpressure, redirects with flush, and halting at
// the end of memory.

module imem_fetch_ctrl #(
    parameter int unsigned                BITSIZE  = 32,
    parameter int unsigned                REGSIZE  = 32,
    parameter int unsigned                DEPTH    = 32,
    parameter logic [REGSIZE-1:0]         RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [REGSIZE-1:0]   imem_addr,
    input  logic [BITSIZE-1:0]   imem_data,
    input  logic                 redirect_valid,
    input  logic [REGSIZE-1:0]   redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITSIZE-1:0]   out_instr,
    output logic [REGSIZE-1:0]   out_pc,
    output logic                 halted,
    output logic [31:0]          issue_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    // End-of-memory bound, one bit wider than the PC so pc+1 never aliases.
    localparam logic [REGSIZE:0] DEPTH_X = (REGSIZE+1)'(DEPTH);
    localparam logic [REGSIZE:0] ONE_X   = (REGSIZE+1)'(1);

    // Saturating increment for the handshake counter: sticks at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        if (&cnt) begin
            return cnt;
        end
        return cnt + 32'd1;
    endfunction

    state_t               state;
    state_t               state_nxt;
    logic [REGSIZE-1:0]   pc_q;
    logic [REGSIZE-1:0]   pc_nxt;
    logic [REGSIZE:0]     pc_inc_x;
    logic                 redirect_in_range;
    logic                 stage_free;
    logic                 load_p0;
    logic                 vld_nxt;
    logic                 issue_fire;

    // Output stage registers (stage p0 sits between memory and decode).
    logic                 vld_p0;
    logic [BITSIZE-1:0]   instr_p0;
    logic [REGSIZE-1:0]   pc_p0;
    logic [31:0]          issue_cnt_q;

    assign pc_inc_x          = {1'b0, pc_q} + ONE_X;
    assign redirect_in_range = ({1'b0, redirect_pc} < DEPTH_X);
    assign stage_free        = !vld_p0 || out_ready;
    assign issue_fire        = vld_p0 && out_ready && !redirect_valid;

    // Next-state, next-PC and output-stage control; redirect outranks fetch.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        load_p0   = 1'b0;
        // A consumed word leaves the stage unless something refills it.
        vld_nxt   = vld_p0 && !out_ready;

        unique case (state)
            IDLE: begin
                vld_nxt = vld_p0;
                if (start) begin
                    state_nxt = FETCH;
                end
            end

            FETCH: begin
                if (redirect_valid) begin
                    vld_nxt   = 1'b0;
                    pc_nxt    = redirect_pc;
                    state_nxt = redirect_in_range ? FETCH : HALT;
                end else if (stage_free) begin
                    load_p0   = 1'b1;
                    vld_nxt   = 1'b1;
                    pc_nxt    = pc_inc_x[REGSIZE-1:0];
                    if (pc_inc_x == DEPTH_X) begin
                        state_nxt = HALT;
                    end
                end else begin
                    vld_nxt = 1'b1;
                end
            end

            HALT: begin
                if (redirect_valid) begin
                    vld_nxt   = 1'b0;
                    pc_nxt    = redirect_pc;
                    state_nxt = redirect_in_range ? FETCH : HALT;
                end
            end

            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
            end
        endcase
    end

    // Control state: FSM, PC, stage valid and handshake counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_q        <= RESET_PC;
            vld_p0      <= 1'b0;
            issue_cnt_q <= 32'd0;
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_nxt;
            vld_p0 <= vld_nxt;
            if (issue_fire) begin
                issue_cnt_q <= sat_inc(issue_cnt_q);
            end
        end
    end

    // ---- stage p0: capture fetched word and its address ----
    // Data half of the output stage; only written on a fetch so it holds
    // steady while decode stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_p0 <= '0;
            pc_p0    <= '0;
        end else if (load_p0) begin
            instr_p0 <= imem_data;
            pc_p0    <= pc_q;
        end
    end

    assign imem_addr   = pc_q;
    assign out_valid   = vld_p0;
    assign out_instr   = instr_p0;
    assign out_pc      = pc_p0;
    assign halted      = (state == HALT);
    assign issue_count = issue_cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed, table-driven bench for imem_fetch_ctrl with a
// behavioural asynchronous-read instruction memory.

module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic [31:0] issue_count;

    int n_cmp;
    int n_bad;

    logic [31:0] mem [32];

    imem_fetch_ctrl #(
        .BITSIZE  (32),
        .REGSIZE  (32),
        .DEPTH    (32),
        .RESET_PC (32'd0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .issue_count    (issue_count)
    );

    assign imem_data = (imem_addr < 32'd32) ? mem[imem_addr[4:0]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_vld;
        logic        e_halt;
        logic [31:0] e_addr;
        logic [31:0] e_cnt;
        logic        chk_d;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs [26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".out_valid"},   {31'd0, out_valid}, 32'd0);
        chk({tag, ".issue_count"}, issue_count,        32'd0);
        chk({tag, ".halted"},      {31'd0, halted},    32'd0);
        chk({tag, ".imem_addr"},   imem_addr,          32'd0);
        chk({tag, ".out_pc"},      out_pc,             32'd0);
        chk({tag, ".out_instr"},   out_instr,          32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + i;
        mem[0]  = 32'h0000_7033;
        mem[1]  = 32'h0010_0093;
        mem[2]  = 32'h0020_0113;
        mem[3]  = 32'h0030_8193;
        mem[8]  = 32'h0020_8433;
        mem[9]  = 32'h4044_04b3;
        mem[14] = 32'h0000_02b7;
        mem[19] = 32'h4d24_4893;
        mem[31] = 32'h0000_0000;

        //           start rv rpc    rdy  vld halt addr   cnt  chkd pc     instr
        vecs[0]  = '{1'b0, 1'b1, 32'd10, 1'b1, 1'b0, 1'b0, 32'd0,  32'd0,  1'b1, 32'd0,  32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 32'd0,  32'd0,  1'b1, 32'd0,  32'h0000_0000};
        vecs[2]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd1,  32'd0,  1'b1, 32'd0,  32'h0000_7033};
        vecs[3]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd2,  32'd1,  1'b1, 32'd1,  32'h0010_0093};
        vecs[4]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd3,  32'd2,  1'b1, 32'd2,  32'h0020_0113};
        vecs[5]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd4,  32'd3,  1'b1, 32'd3,  32'h0030_8193};
        vecs[6]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd5,  32'd4,  1'b1, 32'd4,  32'hA500_0004};
        vecs[7]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd6,  32'd5,  1'b1, 32'd5,  32'hA500_0005};
        // redirect to 19 while pc 5 is pending and decode is ready: discarded, not counted
        vecs[8]  = '{1'b0, 1'b1, 32'd19, 1'b1, 1'b0, 1'b0, 32'd19, 32'd5,  1'b0, 32'd0,  32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd20, 32'd5,  1'b1, 32'd19, 32'h4d24_4893};
        // redirect to 8 under backpressure, then stall three cycles on pc 8
        vecs[10] = '{1'b0, 1'b1, 32'd8,  1'b0, 1'b0, 1'b0, 32'd8,  32'd5,  1'b0, 32'd0,  32'h0};
        vecs[11] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd9,  32'd5,  1'b1, 32'd8,  32'h0020_8433};
        vecs[12] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd9,  32'd5,  1'b1, 32'd8,  32'h0020_8433};
        vecs[13] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd9,  32'd5,  1'b1, 32'd8,  32'h0020_8433};
        vecs[14] = '{1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 32'd9,  32'd5,  1'b1, 32'd8,  32'h0020_8433};
        vecs[15] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd10, 32'd6,  1'b1, 32'd9,  32'h4044_04b3};
        vecs[16] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd11, 32'd7,  1'b1, 32'd10, 32'hA500_000A};
        // jump near the end and run off it
        vecs[17] = '{1'b0, 1'b1, 32'd29, 1'b1, 1'b0, 1'b0, 32'd29, 32'd7,  1'b0, 32'd0,  32'h0};
        vecs[18] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd30, 32'd7,  1'b1, 32'd29, 32'hA500_001D};
        vecs[19] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd31, 32'd8,  1'b1, 32'd30, 32'hA500_001E};
        vecs[20] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b1, 32'd32, 32'd9,  1'b1, 32'd31, 32'h0000_0000};
        vecs[21] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b0, 1'b1, 32'd32, 32'd10, 1'b1, 32'd31, 32'h0000_0000};
        // out-of-range redirect from HALT stays in HALT; in-range one resumes
        vecs[22] = '{1'b0, 1'b1, 32'd40, 1'b1, 1'b0, 1'b1, 32'd40, 32'd10, 1'b0, 32'd0,  32'h0};
        vecs[23] = '{1'b0, 1'b1, 32'd14, 1'b1, 1'b0, 1'b0, 32'd14, 32'd10, 1'b0, 32'd0,  32'h0};
        vecs[24] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd15, 32'd10, 1'b1, 32'd14, 32'h0000_02b7};
        vecs[25] = '{1'b0, 1'b0, 32'd0,  1'b1, 1'b1, 1'b0, 32'd16, 32'd11, 1'b1, 32'd15, 32'hA500_000F};

        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        tick();
        tick();
        chk_reset_state("reset");
        rst_n = 1'b1;
        #2;

        for (int i = 0; i < 26; i++) begin
            start          = vecs[i].start;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            out_ready      = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d.out_valid", i),   {31'd0, out_valid}, {31'd0, vecs[i].e_vld});
            chk($sformatf("v%0d.halted", i),      {31'd0, halted},    {31'd0, vecs[i].e_halt});
            chk($sformatf("v%0d.imem_addr", i),   imem_addr,          vecs[i].e_addr);
            chk($sformatf("v%0d.issue_count", i), issue_count,        vecs[i].e_cnt);
            if (vecs[i].chk_d) begin
                chk($sformatf("v%0d.out_pc", i),    out_pc,    vecs[i].e_pc);
                chk($sformatf("v%0d.out_instr", i), out_instr, vecs[i].e_instr);
            end
        end

        // Stall on pc 15, then assert reset mid-cycle with start held high.
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        tick();
        chk("stall.out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall.out_pc",    out_pc,             32'd15);
        chk("stall.imem_addr", imem_addr,          32'd16);
        #2;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk_reset_state("async_rst");
        tick();
        tick();
        chk("rst_hold.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_hold.imem_addr", imem_addr,          32'd0);
        chk("rst_hold.halted",    {31'd0, halted},    32'd0);
        start = 1'b0;
        #2;
        rst_n = 1'b1;

        // After release the block sits in IDLE until a fresh start.
        out_ready = 1'b1;
        tick();
        tick();
        chk("post_rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst.imem_addr", imem_addr,          32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart.idle_to_fetch", {31'd0, out_valid}, 32'd0);
        tick();
        chk("restart.out_valid", {31'd0, out_valid}, 32'd1);
        chk("restart.out_pc",    out_pc,             32'd0);
        chk("restart.out_instr", out_instr,          32'h0000_7033);
        chk("restart.count",     issue_count,        32'd0);
        tick();
        chk("restart.out_pc1",   out_pc,             32'd1);
        chk("restart.count1",    issue_count,        32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
